// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between the
// pipeline writeback stage and the long-latency unit. A pending scoreboard
// marks registers whose long-latency result has not yet been written, and
// drives a decode-stage hazard. A long-latency result that has been blocked
// for STARVE_LIMIT cycles gets the port for one cycle while writeback stalls.
//
// Handshake (lu_*): the long-latency unit raises lu_valid with lu_addr and
// lu_data and holds all three stable until the cycle where lu_ready is also
// high; that cycle is the transfer and the write lands at its negedge.
// lu_ready never depends on lu_valid's history beyond the starvation counter.
// Issue (issue_*): issue_valid && issue_ready in one cycle marks the
// destination pending; issue_ready is low while that register is pending.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        issue_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  dst_addr,
  output logic        hazard,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data
);

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  logic [31:1] pending_q;
  logic [31:1] pending_d;
  logic [31:0] pend_full;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic        force_q;
  logic        force_d;
  logic        lu_hs;
  logic        lu_blocked;
  logic        issue_set;

  // Register 0 is never pending; prepend a constant zero so any 5-bit
  // address can index the scoreboard directly.
  assign pend_full = {pending_q, 1'b0};

  // Write-port grant: forced long-latency slot, else pipeline, else lu.
  always_comb begin
    lu_ready      = 1'b0;
    wb_stall      = 1'b0;
    rf_write_addr = 5'd0;
    rf_write_data = wb_data;
    if (!rst) begin
      if (force_q) begin
        lu_ready      = 1'b1;
        wb_stall      = 1'b1;
        rf_write_addr = lu_valid ? lu_addr : 5'd0;
        rf_write_data = lu_data;
      end else if (wb_addr != 5'd0) begin
        rf_write_addr = wb_addr;
        rf_write_data = wb_data;
      end else begin
        lu_ready      = 1'b1;
        rf_write_addr = lu_valid ? lu_addr : 5'd0;
        rf_write_data = lu_data;
      end
    end
  end

  // Decode-facing scoreboard lookups; all forced low while in reset.
  always_comb begin
    issue_ready = 1'b0;
    hazard      = 1'b0;
    if (!rst) begin
      issue_ready = !pend_full[issue_addr];
      hazard      = pend_full[rs_addr] | pend_full[rt_addr] | pend_full[dst_addr];
    end
  end

  assign lu_hs      = lu_valid && lu_ready;
  assign lu_blocked = lu_valid && !lu_ready;
  assign issue_set  = issue_valid && issue_ready && (issue_addr != 5'd0);

  // Next scoreboard: clear on completed handshake, set on issue; set wins.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < 32; i++) begin
      if (lu_hs && (lu_addr == 5'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (issue_set && (issue_addr == 5'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  // Starvation tracking: count blocked cycles, arm a one-cycle force slot.
  // A force cycle always has lu_ready high, so it is never blocked and
  // force drops on the following edge regardless of lu_valid.
  always_comb begin
    wait_cnt_d = 4'd0;
    force_d    = 1'b0;
    if (lu_blocked) begin
      if (wait_cnt_q == LIMIT_M1) begin
        force_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      wait_cnt_q <= 4'd0;
      force_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
      force_q    <= force_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_write_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dst_addr;
  logic        hazard;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rf_mem [32];

  regfile_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dst_addr(dst_addr), .hazard(hazard),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
  );

  // Clock and the register file this block feeds (samples on negedge).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_write_addr != 5'd0) rf_mem[rf_write_addr] <= rf_write_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wb_addr = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; dst_addr = 5'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    wb_addr = 5'd5; wb_data = 32'h5555_0005;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h6666_0006;
    rs_addr = 5'd6; rt_addr = 5'd5; dst_addr = 5'd7;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_checks++;
      if (rf_write_addr !== 5'd0) begin n_errors++; $display("FAIL reset_waddr: got %0d want 0", rf_write_addr); end
      n_checks++;
      if (lu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_lu_ready: got %b want 0", lu_ready); end
      n_checks++;
      if (hazard !== 1'b0) begin n_errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
      n_checks++;
      if (wb_stall !== 1'b0 || issue_ready !== 1'b0) begin
        n_errors++; $display("FAIL reset_stall_issue: got stall=%b issue_ready=%b want 0/0", wb_stall, issue_ready);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (rf_write_addr !== 5'd5 || lu_ready !== 1'b0 || wb_stall !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_wb: got addr=%0d lu_ready=%b stall=%b want 5/0/0", rf_write_addr, lu_ready, wb_stall);
    end
    tick();
    wb_addr = 5'd0;
    #2;
    n_checks++;
    if (rf_write_addr !== 5'd6 || lu_ready !== 1'b1) begin
      n_errors++; $display("FAIL post_reset_lu: got addr=%0d lu_ready=%b want 6/1", rf_write_addr, lu_ready);
    end
    tick();
    lu_valid = 1'b0;
    n_checks++;
    if (rf_mem[5] !== 32'h5555_0005 || rf_mem[6] !== 32'h6666_0006) begin
      n_errors++; $display("FAIL post_reset_rf: got r5=%h r6=%h want 55550005/66660006", rf_mem[5], rf_mem[6]);
    end
  endtask

  task automatic test_idle_lu;
    do_reset();
    issue_valid = 1'b1; issue_addr = 5'd7;
    #2;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL idle_issue_r7: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0; rs_addr = 5'd7;
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hDEAD_BEEF;
    #2;
    n_checks++;
    if (lu_ready !== 1'b1 || rf_write_addr !== 5'd7 || rf_write_data !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL idle_lu_grant: got ready=%b addr=%0d data=%h want 1/7/deadbeef", lu_ready, rf_write_addr, rf_write_data);
    end
    n_checks++;
    if (hazard !== 1'b1) begin n_errors++; $display("FAIL idle_hazard_before: got %b want 1", hazard); end
    tick();
    lu_valid = 1'b0;
    #2;
    n_checks++;
    if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
      n_errors++; $display("FAIL idle_pending_clear: got hazard=%b issue_ready=%b want 0/1", hazard, issue_ready);
    end
    n_checks++;
    if (rf_mem[7] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL idle_r7: got %h want deadbeef", rf_mem[7]); end
    tick();
  endtask

  task automatic test_starvation;
    do_reset();
    wb_addr = 5'd3; wb_data = 32'h3333_3333;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h9999_0009;
    for (int c = 0; c < STARVE_LIMIT; c++) begin
      #2;
      n_checks++;
      if (lu_ready !== 1'b0 || wb_stall !== 1'b0 || rf_write_addr !== 5'd3) begin
        n_errors++; $display("FAIL starve_blocked_c%0d: got ready=%b stall=%b addr=%0d want 0/0/3", c, lu_ready, wb_stall, rf_write_addr);
      end
      tick();
    end
    #2;
    n_checks++;
    if (wb_stall !== 1'b1 || lu_ready !== 1'b1 || rf_write_addr !== 5'd9 || rf_write_data !== 32'h9999_0009) begin
      n_errors++; $display("FAIL starve_force: got stall=%b ready=%b addr=%0d data=%h want 1/1/9/99990009", wb_stall, lu_ready, rf_write_addr, rf_write_data);
    end
    tick();
    // New request right after the forced slot: counting restarts from zero.
    lu_addr = 5'd10; lu_data = 32'hAAAA_000A;
    #2;
    n_checks++;
    if (wb_stall !== 1'b0 || rf_write_addr !== 5'd3) begin
      n_errors++; $display("FAIL starve_after: got stall=%b addr=%0d want 0/3", wb_stall, rf_write_addr);
    end
    n_checks++;
    if (rf_mem[9] !== 32'h9999_0009) begin n_errors++; $display("FAIL starve_r9: got %h want 99990009", rf_mem[9]); end
    tick();
    for (int c = 1; c < STARVE_LIMIT; c++) begin
      #2;
      n_checks++;
      if (lu_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_blocked_c%0d: got %b want 0", c, lu_ready); end
      tick();
    end
    #2;
    n_checks++;
    if (wb_stall !== 1'b1 || rf_write_addr !== 5'd10) begin
      n_errors++; $display("FAIL b2b_force: got stall=%b addr=%0d want 1/10", wb_stall, rf_write_addr);
    end
    tick();
    // Dropping lu_valid restarts the count.
    lu_addr = 5'd11;
    tick();
    tick();
    lu_valid = 1'b0;
    tick();
    lu_valid = 1'b1;
    for (int c = 0; c < STARVE_LIMIT; c++) begin
      #2;
      n_checks++;
      if (wb_stall !== 1'b0) begin n_errors++; $display("FAIL starve_restart_c%0d: got stall=%b want 0", c, wb_stall); end
      tick();
    end
    #2;
    n_checks++;
    if (wb_stall !== 1'b1 || rf_write_addr !== 5'd11) begin
      n_errors++; $display("FAIL starve_restart_force: got stall=%b addr=%0d want 1/11", wb_stall, rf_write_addr);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard;
    do_reset();
    issue_valid = 1'b1; issue_addr = 5'd12;
    #2;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL sb_issue1: got %b want 1", issue_ready); end
    tick();
    rs_addr = 5'd12;
    #2;
    n_checks++;
    if (issue_ready !== 1'b0 || hazard !== 1'b1) begin
      n_errors++; $display("FAIL sb_reissue: got issue_ready=%b hazard=%b want 0/1", issue_ready, hazard);
    end
    tick();
    issue_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd12;
    #2;
    n_checks++;
    if (hazard !== 1'b1) begin n_errors++; $display("FAIL sb_rt: got %b want 1", hazard); end
    tick();
    rt_addr = 5'd0; dst_addr = 5'd12;
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h1212_1212;
    #2;
    n_checks++;
    if (hazard !== 1'b1 || lu_ready !== 1'b1) begin
      n_errors++; $display("FAIL sb_dst_hs: got hazard=%b ready=%b want 1/1", hazard, lu_ready);
    end
    tick();
    lu_valid = 1'b0;
    #2;
    n_checks++;
    if (hazard !== 1'b0) begin n_errors++; $display("FAIL sb_cleared: got %b want 0", hazard); end
    tick();
    // Stale result for r12 completes in the same cycle r12 is re-issued.
    lu_valid = 1'b1; issue_valid = 1'b1; issue_addr = 5'd12;
    #2;
    n_checks++;
    if (issue_ready !== 1'b1 || lu_ready !== 1'b1) begin
      n_errors++; $display("FAIL sb_same_cycle: got issue_ready=%b ready=%b want 1/1", issue_ready, lu_ready);
    end
    tick();
    lu_valid = 1'b0; issue_valid = 1'b0;
    #2;
    n_checks++;
    if (hazard !== 1'b1 || issue_ready !== 1'b0) begin
      n_errors++; $display("FAIL sb_set_wins: got hazard=%b issue_ready=%b want 1/0", hazard, issue_ready);
    end
    // Mid-operation reset drops hazard at once and empties the scoreboard.
    rst = 1'b1;
    #1;
    n_checks++;
    if (hazard !== 1'b0) begin n_errors++; $display("FAIL sb_rst_hazard: got %b want 0", hazard); end
    tick();
    rst = 1'b0;
    #2;
    n_checks++;
    if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
      n_errors++; $display("FAIL sb_post_rst: got hazard=%b issue_ready=%b want 0/1", hazard, issue_ready);
    end
    tick();
  endtask

  task automatic test_r0;
    do_reset();
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_addr = 5'd0;
    #2;
    n_checks++;
    if (lu_ready !== 1'b1 || rf_write_addr !== 5'd0 || issue_ready !== 1'b1) begin
      n_errors++; $display("FAIL r0_discard: got ready=%b addr=%0d issue_ready=%b want 1/0/1", lu_ready, rf_write_addr, issue_ready);
    end
    tick();
    lu_valid = 1'b0; issue_valid = 1'b0;
    #2;
    n_checks++;
    if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
      n_errors++; $display("FAIL r0_never_pending: got hazard=%b issue_ready=%b want 0/1", hazard, issue_ready);
    end
    tick();
  endtask

  // Randomized traffic against a rule-level model of the block.
  task automatic test_random;
    bit          m_pend [32];
    int          m_blocked;
    bit          m_force;
    logic [31:0] m_rf [32];
    bit          m_wr [32];
    bit          hold_lu;
    bit          hold_wb;
    bit          e_ready, e_stall, e_issue, e_hazard, hs;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin m_pend[i] = 1'b0; m_wr[i] = 1'b0; m_rf[i] = 32'd0; end
    m_blocked = 0; m_force = 1'b0; hold_lu = 1'b0; hold_wb = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      if (!hold_wb) begin
        wb_addr = ($urandom_range(0, 9) < 4) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data = $urandom;
      end
      if (!hold_lu) begin
        lu_valid = ($urandom_range(0, 9) < 6);
        lu_addr  = 5'($urandom_range(0, 7));
        lu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 5'($urandom_range(0, 7));
      rs_addr     = 5'($urandom_range(0, 7));
      rt_addr     = 5'($urandom_range(0, 7));
      dst_addr    = 5'($urandom_range(0, 7));
      #2;
      e_ready = 1'b0; e_stall = 1'b0; e_addr = 5'd0; e_data = 32'd0;
      e_issue = 1'b0; e_hazard = 1'b0;
      if (!rst) begin
        if (m_force) begin
          e_ready = 1'b1; e_stall = 1'b1;
          e_addr = lu_valid ? lu_addr : 5'd0; e_data = lu_data;
        end else if (wb_addr != 5'd0) begin
          e_addr = wb_addr; e_data = wb_data;
        end else begin
          e_ready = 1'b1;
          e_addr = lu_valid ? lu_addr : 5'd0; e_data = lu_data;
        end
        e_issue  = (issue_addr == 5'd0) || !m_pend[issue_addr];
        e_hazard = m_pend[rs_addr] || m_pend[rt_addr] || m_pend[dst_addr];
      end
      n_checks++;
      if (lu_ready !== e_ready || wb_stall !== e_stall) begin
        n_errors++; $display("FAIL rand_grant c%0d: got ready=%b stall=%b want %b/%b", c, lu_ready, wb_stall, e_ready, e_stall);
      end
      n_checks++;
      if (rf_write_addr !== e_addr || (e_addr != 5'd0 && rf_write_data !== e_data)) begin
        n_errors++; $display("FAIL rand_write c%0d: got addr=%0d data=%h want %0d/%h", c, rf_write_addr, rf_write_data, e_addr, e_data);
      end
      n_checks++;
      if (issue_ready !== e_issue || hazard !== e_hazard) begin
        n_errors++; $display("FAIL rand_sb c%0d: got issue_ready=%b hazard=%b want %b/%b", c, issue_ready, hazard, e_issue, e_hazard);
      end
      hs = lu_valid && e_ready;
      if (rst) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_blocked = 0; m_force = 1'b0;
      end else begin
        if (hs && lu_addr != 5'd0) m_pend[lu_addr] = 1'b0;
        if (issue_valid && e_issue && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
        if (lu_valid && !e_ready) begin
          m_blocked++;
          if (m_blocked == STARVE_LIMIT) begin m_force = 1'b1; m_blocked = 0; end
        end else begin
          m_blocked = 0; m_force = 1'b0;
        end
        if (e_addr != 5'd0) begin m_rf[e_addr] = e_data; m_wr[e_addr] = 1'b1; end
      end
      hold_wb = e_stall;
      hold_lu = lu_valid && !hs;
      tick();
    end
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      if (m_wr[i]) begin
        n_checks++;
        if (rf_mem[i] !== m_rf[i]) begin
          n_errors++; $display("FAIL rand_rf r%0d: got %h want %h", i, rf_mem[i], m_rf[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_idle_lu();
    test_starvation();
    test_scoreboard();
    test_r0();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
